// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute stage and the M-extension unit.
interface muldiv_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;
   modport master (output start, op, rs1, rs2, input busy, done, result);
   modport slave (input start, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 33-edge fixed latency from start to done.
module muldiv_unit (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [2:0]  op_q;
   logic [63:0] acc_q;
   logic [31:0] rem_q, b_q, result_q;
   logic        neg_q, n1_q, divz_q, busy_q, done_q;
   logic        sa_d, sb_d, n1_d, n2_d;
   logic [31:0] am_d, bm_d, quo_d, rem_d, res_d;
   logic [32:0] add_d, sh_d, dif_d;
   logic [63:0] prod_d;
   always_comb begin
      sa_d   = (bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op == 3'b100) | (bus.op == 3'b110);
      sb_d   = (bus.op == 3'b001) | (bus.op == 3'b100) | (bus.op == 3'b110);
      n1_d   = sa_d & bus.rs1[31];
      n2_d   = sb_d & bus.rs2[31];
      am_d   = n1_d ? -bus.rs1 : bus.rs1;
      bm_d   = n2_d ? -bus.rs2 : bus.rs2;
      add_d  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      sh_d   = {rem_q, acc_q[31]};
      dif_d  = sh_d - {1'b0, b_q};
      prod_d = neg_q ? -acc_q : acc_q;
      // signed overflow falls out of the magnitude path: 2^31/1 negated is 0x80000000, rem 0
      quo_d  = divz_q ? 32'hFFFFFFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
      rem_d  = n1_q ? -rem_q : rem_q;
      res_d  = op_q[2] ? (op_q[1] ? rem_d : quo_d) : (op_q[1:0] == 2'b00 ? prod_d[31:0] : prod_d[63:32]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         b_q      <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         n1_q     <= 1'b0;
         divz_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               op_q    <= bus.op;
               acc_q   <= {32'd0, am_d};
               b_q     <= bm_d;
               rem_q   <= '0;
               neg_q   <= n1_d ^ n2_d;
               n1_q    <= n1_d;
               divz_q  <= bus.rs2 == 32'd0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= CALC;
            end
            CALC: begin
               cnt_q <= cnt_q + 5'd1;
               if (op_q[2]) begin
                  rem_q        <= dif_d[32] ? sh_d[31:0] : dif_d[31:0];
                  acc_q[31:0]  <= {acc_q[30:0], ~dif_d[32]};
               end else acc_q <= {add_d, acc_q[31:1]};
               if (cnt_q == 5'd31) state_q <= FIN;
            end
            FIN: begin
               result_q <= res_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic RV32M model.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   muldiv_if m ();
   muldiv_unit dut (.clk(clk), .rst(rst), .bus(m));
   always #5 clk = ~clk;
   function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'd0, b};
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (o)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      m.op = o; m.rs1 = a; m.rs2 = b; m.start = 1'b1;
      @(posedge clk); #1;
      m.start = 1'b0; m.op = 3'($urandom); m.rs1 = $urandom; m.rs2 = $urandom;
   endtask
   task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int ign);
      int n = 0;
      logic bb = 1'b1;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         m.start = (n == ign);
         if (n == ign) begin m.op = 3'($urandom); m.rs1 = $urandom; m.rs2 = $urandom; end
         if (m.done) break;
         bb &= m.busy;
      end
      chk({tag, " latency"}, 32'(n), 32'd33);
      chk({tag, " busy"}, {31'd0, bb}, 32'd1);
      chk({tag, " busyoff"}, {31'd0, m.busy}, 32'd0);
      chk({tag, " result"}, m.result, ref_f(o, a, b));
   endtask
   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int ign);
      go(o, a, b);
      wait_done(tag, o, a, b, ign);
   endtask
   initial begin
      logic [2:0]  o;
      logic [31:0] a, b;
      logic        saw;
      m.start = 1'b0; m.op = '0; m.rs1 = '0; m.rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'd0, m.busy}, 32'd0);
      chk("rst done", {31'd0, m.done}, 32'd0);
      chk("rst result", m.result, 32'd0);
      rst = 1'b0;
      run("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 0);
      chk("mul const", m.result, 32'hFFFFFFEB);
      @(posedge clk); #1;
      chk("done pulse", {31'd0, m.done}, 32'd0);
      chk("result held", m.result, 32'hFFFFFFEB);
      run("mulh", 3'd1, 32'h80000000, 32'h80000000, 0);
      chk("mulh const", m.result, 32'h40000000);
      run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("mulhu const", m.result, 32'hFFFFFFFE);
      run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("mulhsu const", m.result, 32'hFFFFFFFF);
      run("div", 3'd4, 32'hFFFFFFF9, 32'd2, 0);
      chk("div const", m.result, 32'hFFFFFFFD);
      run("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 0);
      chk("rem const", m.result, 32'hFFFFFFFF);
      run("divu", 3'd5, 32'd100, 32'd7, 0);
      chk("divu const", m.result, 32'd14);
      run("remu", 3'd7, 32'd100, 32'd7, 0);
      chk("remu const", m.result, 32'd2);
      run("div0", 3'd4, 32'd5, 32'd0, 0);
      chk("div0 const", m.result, 32'hFFFFFFFF);
      run("remu0", 3'd7, 32'd5, 32'd0, 0);
      chk("remu0 const", m.result, 32'd5);
      run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("divovf const", m.result, 32'h80000000);
      run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("removf const", m.result, 32'd0);
      run("ignore", 3'd5, 32'd100, 32'd7, 10);
      chk("ignore const", m.result, 32'd14);
      run("b2b", 3'd0, 32'd12345, 32'd678, 0);
      go(3'd4, 32'd1000, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", {31'd0, m.busy}, 32'd0);
      chk("abort done", {31'd0, m.done}, 32'd0);
      chk("abort result", m.result, 32'd0);
      rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin @(posedge clk); #1; saw |= m.done; end
      chk("abort nodone", {31'd0, saw}, 32'd0);
      run("mulhu35", 3'd3, 32'd3, 32'd5, 0);
      chk("mulhu35 const", m.result, 32'd0);
      repeat (40) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = $urandom_range(1, 15);
            default: ;
         endcase
         run("rand", o, a, b, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
